// File: rtl/multi_port_occupancy_pkg.sv
// Shared types and helpers for multi-lane occupancy tracking.
// Provides the count-width function, a lane popcount and the flag bundle.
package multi_port_occupancy_pkg;

    typedef struct packed {
        logic full;
        logic almost_full;
        logic empty;
        logic almost_empty;
    } occ_flags_t;

    // Bits needed to hold 0..depth inclusive
    function automatic int clog2_plus1(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Up to 8 lanes; narrower vectors are zero-extended by the caller
    function automatic int popcount(input logic [7:0] bits);
        int n;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            n += int'(bits[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/multi_port_occupancy_lane_popcount.sv
// Counts asserted lanes of a request vector (combinational).
// Ports: lanes (LANES bits in), total (number of set lanes out).
module lane_popcount
    import multi_port_occupancy_pkg::*;
#(
    parameter int LANES = 2,
    parameter int CNTW  = $clog2(LANES + 1)
) (
    input  logic [LANES-1:0] lanes,
    output logic [CNTW-1:0]  total
);

    always_comb begin
        total = CNTW'(popcount(8'(lanes)));
    end

endmodule

// File: rtl/multi_port_occupancy.sv
// Occupancy tracker for a queue with multi-lane push/pop per cycle.
// Ports: clk, rst_n, push, pop, err_clear in; count, free_slots, flags, errors out.
module multi_port_occupancy
    import multi_port_occupancy_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int PUSH_PORTS = 2,
    parameter int POP_PORTS  = 2,
    parameter int AF_THRESH  = 6,
    parameter int AE_THRESH  = 2,
    localparam int CW        = clog2_plus1(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [PUSH_PORTS-1:0] push,
    input  logic [POP_PORTS-1:0]  pop,
    input  logic                  err_clear,
    output logic [CW-1:0]         count,
    output logic [CW-1:0]         free_slots,
    output logic                  full,
    output logic                  almost_full,
    output logic                  empty,
    output logic                  almost_empty,
    output logic                  valid,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int PW = $clog2(PUSH_PORTS + 1);
    localparam int QW = $clog2(POP_PORTS + 1);
    localparam int SW = CW + 2;

    if (DEPTH < 2) begin : g_bad_depth
        $error("DEPTH must be >= 2");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH - 1) begin : g_bad_af
        $error("AF_THRESH out of range");
    end
    if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
        $error("AE_THRESH out of range");
    end

    logic [PW-1:0] np;
    logic [QW-1:0] nq;

    lane_popcount #(.LANES(PUSH_PORTS)) u_push_cnt (
        .lanes (push),
        .total (np)
    );

    lane_popcount #(.LANES(POP_PORTS)) u_pop_cnt (
        .lanes (pop),
        .total (nq)
    );

    logic signed [SW-1:0] sum;
    logic [CW-1:0]        count_next;
    logic                 ovf_evt;
    logic                 unf_evt;
    occ_flags_t           flags_next;
    occ_flags_t           flags_q;

    // Signed sum with headroom so the clamp sees true over/underflow
    always_comb begin
        sum = $signed({2'b00, count})
            + $signed(SW'(np))
            - $signed(SW'(nq));
        ovf_evt    = 1'b0;
        unf_evt    = 1'b0;
        count_next = sum[CW-1:0];
        if (sum < 0) begin
            unf_evt    = 1'b1;
            count_next = '0;
        end else if (sum > $signed(SW'(DEPTH))) begin
            ovf_evt    = 1'b1;
            count_next = CW'(DEPTH);
        end
        flags_next.full         = (count_next == CW'(DEPTH));
        flags_next.almost_full  = (count_next >= CW'(AF_THRESH));
        flags_next.empty        = (count_next == '0);
        flags_next.almost_empty = (count_next <= CW'(AE_THRESH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count      <= '0;
            free_slots <= CW'(DEPTH);
            flags_q    <= '{full: 1'b0, almost_full: 1'b0,
                            empty: 1'b1, almost_empty: 1'b1};
            valid      <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            count      <= count_next;
            free_slots <= CW'(DEPTH) - count_next;
            flags_q    <= flags_next;
            valid      <= ~flags_next.empty;
            // A new error outranks a same-cycle clear
            overflow   <= ovf_evt | (overflow & ~err_clear);
            underflow  <= unf_evt | (underflow & ~err_clear);
        end
    end

    assign full         = flags_q.full;
    assign almost_full  = flags_q.almost_full;
    assign empty        = flags_q.empty;
    assign almost_empty = flags_q.almost_empty;

`ifndef SYNTHESIS
    a_count_max : assert property (@(posedge clk) disable iff (!rst_n)
        count <= CW'(DEPTH));
    a_full_empty : assert property (@(posedge clk) disable iff (!rst_n)
        !(full && empty));
    a_free_sum : assert property (@(posedge clk) disable iff (!rst_n)
        (CW+1)'(free_slots) + (CW+1)'(count) == (CW+1)'(DEPTH));
`endif

endmodule

// File: tb/tb_multi_port_occupancy.sv
// Randomised and directed bench for multi_port_occupancy.
// Reference model tracks occupancy as a plain clamped integer.
module tb_multi_port_occupancy;

    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] push = '0;
    logic [1:0] pop = '0;
    logic       err_clear = 1'b0;
    logic [3:0] count;
    logic [3:0] free_slots;
    logic       full, almost_full, empty, almost_empty, valid;
    logic       overflow, underflow;

    int checks = 0;
    int errors = 0;

    int m_count = 0;
    int m_ovf = 0;
    int m_unf = 0;

    multi_port_occupancy #(
        .DEPTH(DEPTH), .PUSH_PORTS(2), .POP_PORTS(2),
        .AF_THRESH(AF), .AE_THRESH(AE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .push(push), .pop(pop),
        .err_clear(err_clear), .count(count), .free_slots(free_slots),
        .full(full), .almost_full(almost_full), .empty(empty),
        .almost_empty(almost_empty), .valid(valid),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".count"}, int'(count), m_count);
        check({tag, ".free"}, int'(free_slots), DEPTH - m_count);
        check({tag, ".full"}, int'(full), int'(m_count == DEPTH));
        check({tag, ".afull"}, int'(almost_full), int'(m_count >= AF));
        check({tag, ".empty"}, int'(empty), int'(m_count == 0));
        check({tag, ".aempty"}, int'(almost_empty), int'(m_count <= AE));
        check({tag, ".valid"}, int'(valid), int'(m_count != 0));
        check({tag, ".ovf"}, int'(overflow), m_ovf);
        check({tag, ".unf"}, int'(underflow), m_unf);
    endtask

    // Model: pops may consume same-cycle pushes; result clamps to [0, DEPTH]
    task automatic step(input string tag, input logic [1:0] p,
                        input logic [1:0] q, input logic clr);
        int s;
        int ov;
        int un;
        push = p;
        pop = q;
        err_clear = clr;
        @(posedge clk);
        s = m_count + $countones(p) - $countones(q);
        ov = 0;
        un = 0;
        if (s < 0) begin
            s = 0;
            un = 1;
        end else if (s > DEPTH) begin
            s = DEPTH;
            ov = 1;
        end
        m_count = s;
        m_ovf = (ov == 1 || (m_ovf == 1 && !clr)) ? 1 : 0;
        m_unf = (un == 1 || (m_unf == 1 && !clr)) ? 1 : 0;
        #1;
        check_all(tag);
    endtask

    task automatic model_reset();
        m_count = 0;
        m_ovf = 0;
        m_unf = 0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        check_all("reset");

        for (int i = 0; i < 4; i++) step("fill", 2'b11, 2'b00, 1'b0);

        step("to7", 2'b00, 2'b01, 1'b0);
        step("ovf", 2'b11, 2'b00, 1'b0);
        step("ovf_hold", 2'b00, 2'b00, 1'b0);
        step("ovf_hold2", 2'b00, 2'b00, 1'b0);
        step("ovf_clr", 2'b00, 2'b00, 1'b1);
        step("ovf_gone", 2'b00, 2'b00, 1'b0);

        step("bal_full", 2'b11, 2'b11, 1'b0);
        for (int i = 0; i < 4; i++) step("drain", 2'b00, 2'b11, 1'b0);
        step("bal_empty", 2'b01, 2'b10, 1'b0);

        step("to1", 2'b10, 2'b00, 1'b0);
        step("unf", 2'b00, 2'b11, 1'b0);
        step("unf_hold", 2'b00, 2'b00, 1'b0);
        step("unf_clr_evt", 2'b00, 2'b01, 1'b1);
        step("unf_clr", 2'b00, 2'b00, 1'b1);

        for (int i = 0; i < 400; i++) begin
            logic [1:0] p;
            logic [1:0] q;
            p = 2'($urandom);
            q = 2'($urandom);
            if (i % 50 < 20) q = q & 2'($urandom);
            else if (i % 50 >= 35) p = p & 2'($urandom);
            step("rand", p, q, ($urandom_range(0, 15) == 0));
        end

        // Async reset away from any edge, push held through it
        while (m_count != 5) begin
            if (m_count < 5) step("to5", 2'b01, 2'b00, 1'b0);
            else step("to5", 2'b00, 2'b01, 1'b0);
        end
        push = 2'b11;
        pop = 2'b00;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(posedge clk);
        @(posedge clk);
        #1;
        check_all("rst_held");
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst", 2'b11, 2'b00, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
